// File: rtl/mdu_pkg.sv
// mdu_pkg: shared MDU/ALU op encodings and default MDU latencies.
package mdu_pkg;
  typedef enum logic [3:0] {
    MDU_NOP = 4'd0,
    MULT    = 4'd1,
    MULTU   = 4'd2,
    DIV     = 4'd3,
    DIVU    = 4'd4,
    MTHI    = 4'd5,
    MTLO    = 4'd6
  } mdu_op_e;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR,
    ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;
  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;
  localparam int CNT_W = 8;
endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational product and quotient/remainder from latched operands.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        div0_o
);
  logic signed [63:0] prod_s;
  logic [63:0] prod_u;
  logic a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag;
  always_comb begin
    prod_s = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    prod_u = {32'd0, a_i} * {32'd0, b_i};
    a_neg  = (op_i == DIV) & a_i[31];
    b_neg  = (op_i == DIV) & b_i[31];
    a_mag  = a_neg ? -a_i : a_i;
    b_mag  = b_neg ? -b_i : b_i;
    div0_o = ((op_i == DIV) || (op_i == DIVU)) && (b_i == 32'd0);
    // Magnitude division keeps 0x80000000 / -1 well defined (wraps to 0x80000000).
    b_safe = (b_i == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    hi_o   = (op_i == MULT) ? prod_s[63:32] : (op_i == MULTU) ? prod_u[63:32] :
             a_neg ? -r_mag : r_mag;
    lo_o   = (op_i == MULT) ? prod_s[31:0] : (op_i == MULTU) ? prod_u[31:0] :
             (a_neg ^ b_neg) ? -q_mag : q_mag;
  end
endmodule

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit holding HI/LO with a start/busy handshake.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  MduCtrl,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  typedef enum logic {IDLE, RUN} state_e;
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0] op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
  logic [31:0] res_hi, res_lo;
  logic div0, is_mul, is_div;
  mdu_calc u_calc (
    .op_i  (op_q),
    .a_i   (a_q),
    .b_i   (b_q),
    .hi_o  (res_hi),
    .lo_o  (res_lo),
    .div0_o(div0)
  );
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    is_mul  = (MduCtrl == MULT) || (MduCtrl == MULTU);
    is_div  = (MduCtrl == DIV) || (MduCtrl == DIVU);
    if (state_q == IDLE) begin
      if (start && (is_mul || is_div)) begin
        op_d    = MduCtrl;
        a_d     = A;
        b_d     = B;
        cnt_d   = is_div ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
        state_d = RUN;
      end
      if (start && MduCtrl == MTHI) hi_d = A;
      if (start && MduCtrl == MTLO) lo_d = A;
    end else begin
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        state_d = IDLE;
        hi_d    = div0 ? hi_q : res_hi;
        lo_d    = div0 ? lo_q : res_lo;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
  assign busy = (state_q == RUN);
  assign HI   = hi_q;
  assign LO   = lo_q;
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed-vector self-checking bench for mdu_unit.
module tb_mdu_unit;
  import mdu_pkg::*;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [3:0] MduCtrl = 4'd0;
  logic [31:0] A = '0, B = '0;
  logic busy;
  logic [31:0] HI, LO;
  logic [31:0] exp_hi = '0, exp_lo = '0;
  int n_chk = 0, n_fail = 0;
  mdu_unit dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .MduCtrl(MduCtrl),
    .A      (A),
    .B      (B),
    .busy   (busy),
    .HI     (HI),
    .LO     (LO)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [31:0] eh,
                        input logic [31:0] el, input bit intrude);
    int n;
    start = 1'b1; MduCtrl = op; A = a; B = b;
    tick();
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      start = 1'b0;
      if (n == 1) begin
        chk({tag, "_hi_hold"}, HI, exp_hi);
        chk({tag, "_lo_hold"}, LO, exp_lo);
      end
      if (intrude && n == 2) begin
        start = 1'b1; MduCtrl = MTLO; A = 32'hDEADBEEF; B = 32'h99;
      end
      tick();
    end
    start = 1'b0;
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    exp_hi = eh;
    exp_lo = el;
    chk({tag, "_hi"}, HI, exp_hi);
    chk({tag, "_lo"}, LO, exp_lo);
  endtask
  task automatic single(input string tag, input logic [3:0] op, input logic [31:0] a);
    start = 1'b1; MduCtrl = op; A = a;
    tick();
    start = 1'b0;
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_hi"}, HI, exp_hi);
    chk({tag, "_lo"}, LO, exp_lo);
  endtask
  initial begin
    repeat (2) tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    reset_n = 1'b1;
    tick();
    run_op("mult", MULT, 32'hFFFFFFFE, 32'h3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0);
    run_op("multu", MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 32'hFFFFFFFE, 32'h1, 1'b0);
    run_op("div", DIV, 32'hFFFFFFF9, 32'h2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_op("divu", DIVU, 32'hFFFFFFF9, 32'h2, 10, 32'h1, 32'h7FFFFFFC, 1'b0);
    run_op("div_ovf", DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000, 1'b0);
    run_op("mult_b0", MULT, 32'h1234, 32'h0, 5, 32'h0, 32'h0, 1'b0);
    exp_hi = 32'h11111111;
    single("mthi", MTHI, 32'h11111111);
    exp_lo = 32'h22222222;
    single("mtlo", MTLO, 32'h22222222);
    run_op("div0", DIV, 32'h64, 32'h0, 10, 32'h11111111, 32'h22222222, 1'b0);
    run_op("divu0", DIVU, 32'h64, 32'h0, 10, 32'h11111111, 32'h22222222, 1'b0);
    single("nop7", 4'd7, 32'hCAFEF00D);
    single("nop0", MDU_NOP, 32'hCAFEF00D);
    run_op("ignore", MULT, 32'h7, 32'h6, 5, 32'h0, 32'h2A, 1'b1);
    exp_hi = 32'h55;
    single("mthi2", MTHI, 32'h55);
    start = 1'b1; MduCtrl = DIV; A = 32'd100; B = 32'd7;
    tick();
    start = 1'b0;
    repeat (3) tick();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", HI, 32'd0);
    chk("arst_lo", LO, 32'd0);
    tick();
    reset_n = 1'b1;
    exp_hi = '0;
    exp_lo = '0;
    tick();
    run_op("mult_post", MULT, 32'd3, 32'd4, 5, 32'h0, 32'd12, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit in the EX stage, beside the combinational ALU.
- Takes operands A/B from the same forwarded EX operands as the ALU.
- Holds the architectural HI/LO registers.
- Exposes a start/busy handshake that the hazard unit uses to stall later HI/LO-touching instructions.

Parameters:
- MUL_LAT, 5, cycles busy is high for MULT/MULTU
- DIV_LAT, 10, cycles busy is high for DIV/DIVU

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- start  input  1  EX-stage instruction is an MDU op this cycle; qualifies MduCtrl
- MduCtrl  input  4  op: 1=MULT, 2=MULTU, 3=DIV, 4=DIVU, 5=MTHI, 6=MTLO; other values = no-op
- A  input  32  rs operand (dividend / multiplicand / MTHI-MTLO source)
- B  input  32  rt operand (divisor / multiplier)
- busy  output  1  multi-cycle op in flight
- HI  output  32  HI register
- LO  output  32  LO register

Behaviour:
- Reset (reset_n low, asynchronous, any time including mid-op):
  - HI=0, LO=0, busy=0, cycle counter=0.
  - Latched operands and op are cleared.
  - The in-flight result is discarded.
- States: IDLE and RUN. A down-counter holds the remaining cycles.
- IDLE, start=1, MduCtrl in 1..4, at the clock edge:
  - Latch A, B and op.
  - Load counter with MUL_LAT (ops 1,2) or DIV_LAT (ops 3,4).
  - busy=1 from the next cycle; go to RUN.
- RUN, each edge:
  - Decrement the counter.
  - On the edge where the counter goes 1→0: write HI/LO, busy=0, go to IDLE.
  - busy is therefore high for exactly MUL_LAT or DIV_LAT cycles after the start edge.
  - The next op may start on the cycle busy reads 0.
- Results, computed from the latched operands only (changing A/B during RUN has no effect):
  - MULT: {HI,LO} = signed 64-bit product.
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - DIV: LO = signed quotient truncated toward zero; HI = remainder, same sign as the dividend.
    - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - DIVU: LO = unsigned quotient, HI = unsigned remainder.
  - Divisor 0 (DIV/DIVU): full DIV_LAT busy period; HI and LO stay unchanged.
- MTHI/MTLO in IDLE with start=1: HI<=A (resp. LO<=A) at that edge; busy stays 0; single cycle.
- start=1 while busy=1, any op: ignored, with no state change. The hazard unit must stall EX while (start|busy) for MDU ops and MFHI/MFLO; the unit does not rely on this.
- start=1 with MduCtrl 0 or ≥7: no effect.
- HI/LO are registered outputs; they show old values for the whole RUN period and new values from the completion edge.
- MFHI/MFLO reads are plain muxing of HI/LO outside this block.

Decomposition:
- Shared package (mdu_pkg):
  - MduCtrl encodings: MDU_NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6.
  - Default latencies MUL_LAT, DIV_LAT.
  - The same package holds ALU op encodings so the decoder imports both from one place.
- One natural sub-module, mdu_calc: combinational 64-bit product plus quotient/remainder from the latched operands and op, including the div-by-zero flag. mdu_unit keeps the FSM, counter and HI/LO registers.

Test Plan:
- Reset, then MULT A=0xFFFFFFFE (-2), B=0x00000003 → busy high for 5 cycles; at completion HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001 after 5 cycles.
- DIV A=0xFFFFFFF9 (-7), B=2 → busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU on the same operands → LO=0x7FFFFFFC, HI=1.
- Preload via MTHI A=0x11111111 and MTLO A=0x22222222 (each one cycle, busy=0), then DIV B=0 → busy 10 cycles; HI=0x11111111, LO=0x22222222 unchanged.
- Start MULT, and on cycle 2 of busy drive start with MTLO A=0xDEADBEEF and change A/B → ignored; the product equals the originally latched operands; LO≠0xDEADBEEF.
- Start DIV, assert reset_n=0 at cycle 4 (asynchronously, between edges) → busy, HI, LO go to 0 immediately. After release, a new MULT 3×4 gives LO=12, HI=0 after 5 cycles.
